// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - round-robin arbiter sharing the instruction ROM read port between fetch and load
module rom_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ROM_DEPTH = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              IfReqValid,
    input  logic [ADDR_W-1:0] IfAddr,
    output logic              IfReqReady,
    input  logic              IfFlush,
    output logic              IfRespValid,
    input  logic              IfRespReady,
    input  logic              LdReqValid,
    input  logic [ADDR_W-1:0] LdAddr,
    output logic              LdReqReady,
    output logic              LdRespValid,
    input  logic              LdRespReady,
    output logic [DATA_W-1:0] RespData,
    output logic              RespErr,
    output logic [ADDR_W-1:0] RomAddr,
    input  logic [DATA_W-1:0] RomData
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] RESP    = 1'b1;
    localparam logic       PORT_IF = 1'b0;
    localparam logic       PORT_LD = 1'b1;

    // One extra bit so the ROM byte size never wraps inside ADDR_W.
    localparam int                ROM_BYTES_W = ADDR_W + 1;
    localparam logic [ADDR_W:0]   ROM_BYTES   = ROM_BYTES_W'(ROM_DEPTH) << 2;

    logic [0:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;

    logic if_drop;
    logic consume;
    logic can_accept;
    logic if_elig;
    logic ld_elig;
    logic win_ld;
    logic accept;
    logic addr_fault;

    // Arbitration, ROM address steering and next-state computation.
    always_comb begin
        // An If-owned response is dropped by flush; a drop also frees the slot so Ld may take it.
        if_drop    = (state_q == RESP) && (owner_q == PORT_IF) && IfFlush;
        consume    = (state_q == RESP) && !if_drop &&
                     ((owner_q == PORT_IF) ? IfRespReady : LdRespReady);
        can_accept = (state_q == IDLE) || consume || if_drop;

        if_elig = IfReqValid && !IfFlush;
        ld_elig = LdReqValid;
        // With both eligible, the port that did not win last time goes first.
        win_ld  = ld_elig && (!if_elig || (last_grant_q == PORT_IF));
        accept  = rst_n && can_accept && (if_elig || ld_elig);

        IfReqReady = accept && !win_ld;
        LdReqReady = accept && win_ld;
        RomAddr    = (accept && win_ld) ? LdAddr : IfAddr;

        addr_fault = (RomAddr[1:0] != 2'b00) || ({1'b0, RomAddr} >= ROM_BYTES);

        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;

        if (accept) begin
            state_d      = RESP;
            owner_d      = win_ld;
            last_grant_d = win_ld;
            resp_data_d  = addr_fault ? '0 : RomData;
            resp_err_d   = addr_fault;
        end else if (consume || if_drop) begin
            state_d = IDLE;
        end
    end

    // State and registered response word; reset clears any held response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= PORT_IF;
            last_grant_q <= PORT_LD;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Response outputs come straight from flops, so RespReady never reaches RespData.
    always_comb begin
        IfRespValid = (state_q == RESP) && (owner_q == PORT_IF);
        LdRespValid = (state_q == RESP) && (owner_q == PORT_LD);
        RespData    = resp_data_q;
        RespErr     = resp_err_q;
    end

endmodule
